// File: rtl/nios_address_seq_if.sv
// Bus bundle for nios_address_seq.
// Carries the Avalon-MM register port (address, chipselect, write_n,
// writedata, readdata), the address stream toward the pixel fetch logic
// (out_port, addr_valid, addr_ready) and the interrupt line (irq).
// slave  : the sequencer's view (decodes the bus, sources the stream).
// master : the CPU/downstream view (drives the bus, accepts the stream).
interface nios_address_seq_if #(
  parameter int ADDR_W = 8
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [ADDR_W-1:0] out_port;
  logic              addr_valid;
  logic              addr_ready;
  logic              irq;

  modport slave (
    input  address, chipselect, write_n, writedata, addr_ready,
    output readdata, out_port, addr_valid, irq
  );

  modport master (
    output address, chipselect, write_n, writedata, addr_ready,
    input  readdata, out_port, addr_valid, irq
  );
endinterface

// File: rtl/nios_address_seq.sv
// Avalon-MM programmable address sequencer.
// Software programs BASE, STRIDE and COUNT, then writes start; the block
// emits COUNT addresses (BASE, BASE+STRIDE, ...) on out_port using a
// valid/ready handshake, optionally inserting GAP_CYCLES idle cycles after
// each accepted address, and raises done (and irq when enabled) at the end.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : register port, address stream and irq (slave modport)
// Register map: 0 BASE, 1 STRIDE, 2 COUNT, 3 CTRL(write)/STATUS(read).
module nios_address_seq #(
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_address_seq_if.slave     bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero, so the
  // GAP state lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        stride_reg;
  logic [7:0]        count_reg;
  logic              irq_en;
  logic              done;

  // Shadow copies used by the running sequence.
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] out_reg;
  logic [7:0]        stp;
  logic [7:0]        remaining;
  logic [7:0]        gap_cnt;

  logic              wr;
  logic              ctrl_wr;
  logic              start_req;
  logic              abort_req;
  logic              w1c;
  logic              xfer;
  logic              last;
  logic [ADDR_W-1:0] nxt_addr;
  logic              unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign ctrl_wr   = wr & (bus.address == 2'd3);
  // Abort takes precedence over start in the same write; start is only
  // honoured while idle.
  assign start_req = ctrl_wr & bus.writedata[0] & ~bus.writedata[1] & (state == IDLE);
  assign abort_req = ctrl_wr & bus.writedata[1];
  assign w1c       = ctrl_wr & bus.writedata[3];
  assign xfer      = (state == ACTIVE) & bus.addr_ready;
  assign last      = xfer & (remaining == 8'd1);
  assign nxt_addr  = cur + ADDR_W'(stp);
  assign unused_wd = ^bus.writedata;

  assign bus.addr_valid = (state == ACTIVE);
  assign bus.out_port   = out_reg;
  assign bus.irq        = done & irq_en;

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(base_reg);
      2'd1:    bus.readdata = 32'(stride_reg);
      2'd2:    bus.readdata = 32'(count_reg);
      default: bus.readdata = {16'd0, remaining, 5'd0, irq_en, done, (state != IDLE)};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_reg   <= '0;
      stride_reg <= 8'd0;
      count_reg  <= 8'd0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      cur        <= '0;
      out_reg    <= '0;
      stp        <= 8'd0;
      remaining  <= 8'd0;
      gap_cnt    <= 8'd0;
    end else begin
      // Programming registers are independent of the running sequence.
      if (wr) begin
        case (bus.address)
          2'd0:    base_reg   <= bus.writedata[ADDR_W-1:0];
          2'd1:    stride_reg <= bus.writedata[7:0];
          2'd2:    count_reg  <= bus.writedata[7:0];
          default: irq_en     <= bus.writedata[2];
        endcase
      end

      // Completion beats a same-cycle W1C; an abort never reports done.
      if ((last & ~abort_req) | (start_req & (count_reg == 8'd0)))
        done <= 1'b1;
      else if (w1c | start_req)
        done <= 1'b0;

      case (state)
        IDLE: begin
          if (start_req && (count_reg != 8'd0)) begin
            cur       <= base_reg;
            out_reg   <= base_reg;
            stp       <= stride_reg;
            remaining <= count_reg;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            remaining <= remaining - 8'd1;
            cur       <= nxt_addr;
            // out_port keeps the last accepted address once the sequence ends.
            if (!last && !abort_req) out_reg <= nxt_addr;
            if (last || abort_req) begin
              state <= IDLE;
            end else if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (abort_req) begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (abort_req)
            state <= IDLE;
          else if (gap_cnt == 8'd0)
            state <= ACTIVE;
          else
            gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_address_seq.sv
module tb_nios_address_seq;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] q0[$];
  logic [31:0] qg[$];

  nios_address_seq_if #(.ADDR_W(8)) if0 ();
  nios_address_seq_if #(.ADDR_W(8)) ifg ();

  nios_address_seq #(.ADDR_W(8), .GAP_CYCLES(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  nios_address_seq #(.ADDR_W(8), .GAP_CYCLES(2)) dut_gap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit g, input logic [1:0] a, input logic [31:0] d);
    if (g) begin
      ifg.address = a; ifg.writedata = d; ifg.chipselect = 1'b1; ifg.write_n = 1'b0;
    end else begin
      if0.address = a; if0.writedata = d; if0.chipselect = 1'b1; if0.write_n = 1'b0;
    end
    step(1);
    ifg.chipselect = 1'b0; ifg.write_n = 1'b1;
    if0.chipselect = 1'b0; if0.write_n = 1'b1;
  endtask

  task automatic rd_chk(input bit g, input logic [1:0] a, input string nm, input logic [31:0] exp);
    logic [31:0] d;
    if (g) ifg.address = a; else if0.address = a;
    #1;
    d = g ? ifg.readdata : if0.readdata;
    chk(nm, d, exp);
    step(1);
  endtask

  // Scoreboard monitors: compare every presented address with the queue
  // head; pop only when the handshake completes.
  always @(negedge clk) begin
    if (reset_n && if0.addr_valid) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL seq0_unexpected: got addr 0x%02h expected no valid", if0.out_port);
      end else begin
        chk("seq0_addr", 32'(if0.out_port), q0[0]);
        if (if0.addr_ready) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && ifg.addr_valid) begin
      if (qg.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL seqg_unexpected: got addr 0x%02h expected no valid", ifg.out_port);
      end else begin
        chk("seqg_addr", 32'(ifg.out_port), qg[0]);
        if (ifg.addr_ready) void'(qg.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] vpat [8];
    vpat = '{1, 0, 0, 1, 0, 0, 1, 0};
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    if0.address = 2'd0; if0.chipselect = 1'b0; if0.write_n = 1'b1;
    if0.writedata = 32'd0; if0.addr_ready = 1'b0;
    ifg.address = 2'd0; ifg.chipselect = 1'b0; ifg.write_n = 1'b1;
    ifg.writedata = 32'd0; ifg.addr_ready = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);

    // Reset state
    chk("rst_valid", 32'(if0.addr_valid), 32'd0);
    chk("rst_out", 32'(if0.out_port), 32'd0);
    chk("rst_irq", 32'(if0.irq), 32'd0);
    rd_chk(0, 2'd0, "rst_base", 32'd0);
    rd_chk(0, 2'd3, "rst_ctrl", 32'd0);

    // 1: back-to-back sequence
    if0.addr_ready = 1'b1;
    wr(0, 2'd0, 32'h10);
    wr(0, 2'd1, 32'd4);
    wr(0, 2'd2, 32'd3);
    q0.push_back(32'h10); q0.push_back(32'h14); q0.push_back(32'h18);
    wr(0, 2'd3, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(if0.addr_valid), (i < 3) ? 32'd1 : 32'd0);
      step(1);
    end
    rd_chk(0, 2'd3, "t1_status", 32'h0000_0002);
    chk("t1_out_hold", 32'(if0.out_port), 32'h18);

    // 2: address wrap
    wr(0, 2'd0, 32'hFC);
    wr(0, 2'd1, 32'd8);
    wr(0, 2'd2, 32'd2);
    q0.push_back(32'hFC); q0.push_back(32'h04);
    wr(0, 2'd3, 32'h1);
    step(4);
    chk("t2_out_hold", 32'(if0.out_port), 32'h04);
    chk("t2_valid", 32'(if0.addr_valid), 32'd0);
    rd_chk(0, 2'd3, "t2_status", 32'h0000_0002);

    // 3: stall with ready low
    if0.addr_ready = 1'b0;
    wr(0, 2'd0, 32'h20);
    wr(0, 2'd1, 32'd1);
    wr(0, 2'd2, 32'd4);
    q0.push_back(32'h20); q0.push_back(32'h21); q0.push_back(32'h22); q0.push_back(32'h23);
    wr(0, 2'd3, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", 32'(if0.addr_valid), 32'd1);
      chk("t3_stall_out", 32'(if0.out_port), 32'h20);
      step(1);
    end
    rd_chk(0, 2'd3, "t3_stall_status", 32'h0000_0401);
    if0.addr_ready = 1'b1;
    step(6);
    rd_chk(0, 2'd3, "t3_status", 32'h0000_0002);

    // 4: gap cycles between transfers
    ifg.addr_ready = 1'b1;
    wr(1, 2'd0, 32'h30);
    wr(1, 2'd1, 32'd2);
    wr(1, 2'd2, 32'd3);
    qg.push_back(32'h30); qg.push_back(32'h32); qg.push_back(32'h34);
    wr(1, 2'd3, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_valid_pat", 32'(ifg.addr_valid), vpat[i]);
      if (i == 1) chk("t4_gap_out", 32'(ifg.out_port), 32'h32);
      step(1);
    end
    rd_chk(1, 2'd3, "t4_status", 32'h0000_0002);

    // 5: abort coincident with the third transfer, then restart
    wr(0, 2'd0, 32'h40);
    wr(0, 2'd1, 32'h10);
    wr(0, 2'd2, 32'd5);
    q0.push_back(32'h40); q0.push_back(32'h50); q0.push_back(32'h60);
    wr(0, 2'd3, 32'h1);
    step(2);
    wr(0, 2'd3, 32'h2);
    chk("t5_valid", 32'(if0.addr_valid), 32'd0);
    chk("t5_out", 32'(if0.out_port), 32'h60);
    rd_chk(0, 2'd3, "t5_status", 32'h0000_0200);
    for (int i = 0; i < 5; i++) q0.push_back(32'h40 + 32'(i) * 32'h10);
    wr(0, 2'd3, 32'h1);
    step(7);
    rd_chk(0, 2'd3, "t5_restart_status", 32'h0000_0002);

    // 6: zero count, irq, W1C, COUNT written while busy
    wr(0, 2'd2, 32'd0);
    wr(0, 2'd3, 32'h5);
    chk("t6_irq", 32'(if0.irq), 32'd1);
    chk("t6_valid", 32'(if0.addr_valid), 32'd0);
    rd_chk(0, 2'd3, "t6_status", 32'h0000_0006);
    wr(0, 2'd3, 32'hC);
    chk("t6_irq_w1c", 32'(if0.irq), 32'd0);
    rd_chk(0, 2'd3, "t6_w1c_status", 32'h0000_0004);
    if0.addr_ready = 1'b0;
    wr(0, 2'd0, 32'h00);
    wr(0, 2'd1, 32'd3);
    wr(0, 2'd2, 32'd2);
    q0.push_back(32'h00); q0.push_back(32'h03);
    wr(0, 2'd3, 32'h5);
    wr(0, 2'd2, 32'd4);
    rd_chk(0, 2'd3, "t6_busy_status", 32'h0000_0205);
    rd_chk(0, 2'd2, "t6_count_reg", 32'd4);
    if0.addr_ready = 1'b1;
    step(4);
    rd_chk(0, 2'd3, "t6_run_status", 32'h0000_0006);
    chk("t6_irq_done", 32'(if0.irq), 32'd1);
    q0.push_back(32'h00); q0.push_back(32'h03); q0.push_back(32'h06); q0.push_back(32'h09);
    wr(0, 2'd3, 32'h5);
    step(6);
    rd_chk(0, 2'd3, "t6_new_count_status", 32'h0000_0006);

    // Reset asserted mid-sequence
    if0.addr_ready = 1'b0;
    wr(0, 2'd0, 32'h77);
    q0.push_back(32'h77);
    wr(0, 2'd3, 32'h5);
    step(2);
    reset_n = 1'b0;
    #2;
    chk("mrst_valid", 32'(if0.addr_valid), 32'd0);
    chk("mrst_out", 32'(if0.out_port), 32'd0);
    chk("mrst_irq", 32'(if0.irq), 32'd0);
    if0.address = 2'd3;
    #1;
    chk("mrst_ctrl", if0.readdata, 32'd0);
    if0.address = 2'd0;
    #1;
    chk("mrst_base", if0.readdata, 32'd0);
    q0.delete();
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("mrst_idle_valid", 32'(if0.addr_valid), 32'd0);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("qg_drained", 32'(qg.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_address_seq.md
Name: nios_address_seq

Overview:
Avalon-MM slave sequencer that drives the image-buffer address bus on behalf of the Nios. Software programs a base address, stride and count, then issues start. The block generates the address sequence on out_port with a valid/ready handshake to the downstream pixel fetch logic and raises done/irq on completion. The CPU is then freed from issuing one PIO write per address.

Parameters:
ADDR_W, 8, width of out_port and the internal address accumulator (1..16)
GAP_CYCLES, 0, minimum idle cycles between accepted addresses (0..255)

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational from address, zero-extended
out_port  output  ADDR_W  current sequence address
addr_valid  output  1  out_port holds a valid address
addr_ready  input  1  downstream accepts address when high with addr_valid
irq  output  1  done & irq_en

Behaviour:
- Write occurs when chipselect & ~write_n. Reads have no side effects.
- Register map:
  - 0 BASE[ADDR_W-1:0], R/W.
  - 1 STRIDE[7:0], R/W.
  - 2 COUNT[7:0], R/W.
  - 3 CTRL/STATUS.
    - Write: bit0 start, bit1 abort, bit2 irq_en (stored), bit3 W1C done.
    - Read: bit0 busy, bit1 done, bit2 irq_en, [15:8] remaining.
- Reset values: all registers 0, state IDLE, out_port 0, addr_valid 0, irq 0, readdata reflects zeros.
- State IDLE:
  - addr_valid 0; out_port holds last issued address.
  - On start with COUNT!=0:
    - Shadow-load cur=BASE, stp=STRIDE, remaining=COUNT; clear done.
    - Next cycle: ACTIVE.
  - On start with COUNT==0: done=1 next cycle; stay IDLE.
- State ACTIVE:
  - addr_valid=1, out_port=cur; busy=1.
  - Transfer = addr_valid & addr_ready; remaining-=1 and cur=cur+stp (mod 2^ADDR_W, wrap silently).
  - If post-transfer remaining==0: IDLE and done=1 next cycle.
  - Else if GAP_CYCLES>0: GAP.
  - Else stay ACTIVE with the new address next cycle (back-to-back, one address per cycle max).
  - Without ready: out_port and addr_valid held stable (no change while valid & ~ready).
- State GAP:
  - addr_valid=0; gap counter runs GAP_CYCLES cycles, then ACTIVE.
  - out_port already shows the next address.
- BASE/STRIDE/COUNT writes while busy update the registers only; the running sequence uses shadow copies.
- Start while busy: ignored.
- Abort (any state):
  - IDLE next cycle, addr_valid=0, done not set, remaining readback frozen at aborted value.
  - Abort coincident with a transfer: the transfer counts (remaining/cur update), then IDLE.
  - Abort and start in the same write: abort wins, no sequence launched.
- done:
  - Sticky until W1C bit3 or next start.
  - W1C and completion in the same cycle: completion wins (done=1).
- irq = done & irq_en, registered-free combinational; irq_en writable any time.
- Reset asserted mid-sequence: immediate return to reset values; no partial state retained.
- readdata upper bits are 0; unused CTRL bits read 0.

Test Plan:
1. BASE=0x10, STRIDE=4, COUNT=3, start, addr_ready tied 1, GAP 0 -> out_port 0x10,0x14,0x18 on three consecutive valid cycles. Then addr_valid 0, done=1, busy=0, remaining=0.
2. BASE=0xFC, STRIDE=8, COUNT=2, ready 1 -> addresses 0xFC then 0x04 (wrap). Final out_port holds 0x04 in IDLE.
3. COUNT=4, addr_ready low 5 cycles then high -> out_port/addr_valid stable while stalled. Four transfers total, done set after the fourth.
4. GAP_CYCLES=2, COUNT=3, ready 1 -> addr_valid pattern 1,0,0,1,0,0,1 then 0. Addresses advance by STRIDE.
5. COUNT=5, abort after 2nd transfer with ready high in that cycle -> 3 transfers total counted, remaining=2, done=0, addr_valid 0. Re-start runs a full 5-address sequence from BASE.
6. irq_en=1, COUNT=0, start -> done=1, irq=1 with no addr_valid. W1C bit3 -> irq 0. Write COUNT during an active run -> current run unaffected, next start uses the new value.
